bmu_iterative: RTL

Multi-cycle companion to the combinational bit manipulation unit. It executes the Zbb/Zbc operations that are too costly in one cycle: CLZ, CTZ, CPOP, CLMUL, CLMULH and CLMULR. It is parametrised in data width and in bits processed per cycle. It sits beside the ALU/BMU in the execute stage and stalls the pipeline through a start/busy/done handshake.

---
 rtl/bmu_iterative.sv | 103 ++++++++++
 1 files changed

// File: rtl/bmu_iterative.sv
// bmu_iterative: multi-cycle CLZ/CTZ/CPOP/CLMUL/CLMULH/CLMULR unit with start/busy/done handshake
module bmu_iterative #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      option,
  input  logic [XLEN-1:0] in_x,
  input  logic [XLEN-1:0] in_y,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int NCYC = XLEN / STEP;
  localparam int CW   = $clog2(NCYC) + 1;
  localparam int NW   = $clog2(XLEN) + 1;
  localparam logic [4:0] OP_CLMUL = 5'd1, OP_CLMULH = 5'd2, OP_CLMULR = 5'd3;
  localparam logic [4:0] OP_CLZ = 5'd4, OP_CPOP = 5'd5;

  if (XLEN % STEP != 0) begin : g_bad_step
    $error("bmu_iterative: STEP must divide XLEN");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              r_state;
  logic [4:0]          r_op;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_sh, r_acc, w_acc;
  logic [XLEN-1:0]     r_y, w_res;
  logic [NW-1:0]       r_num, w_num;
  logic                r_found, w_found, w_bit, w_ok, w_left;

  // CLZ and CLMUL walk the operand upward via left shifts; CTZ/CPOP walk it down
  always_comb begin
    w_num   = r_num;
    w_found = r_found;
    w_acc   = r_acc;
    w_bit   = 1'b0;
    for (int j = 0; j < STEP; j++) begin
      w_bit   = (r_op == OP_CLZ) ? r_sh[XLEN-1-j] : r_sh[j];
      w_found = w_found | w_bit;
      w_num   = w_num + NW'((r_op == OP_CPOP) ? w_bit : !w_found);
      w_acc   = r_y[j] ? (w_acc ^ (r_sh << j)) : w_acc;
    end
    w_res  = (r_op == OP_CLMUL)  ? w_acc[XLEN-1:0] :
             (r_op == OP_CLMULH) ? w_acc[2*XLEN-1:XLEN] :
             (r_op == OP_CLMULR) ? w_acc[2*XLEN-2:XLEN-1] : XLEN'(w_num);
    w_ok   = (option >= OP_CLMUL) && (option <= 5'd6);
    w_left = (r_op == OP_CLZ) || (r_op <= OP_CLMULR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      r_num   <= '0;
      r_found <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (r_state == RUN) begin
      r_cnt   <= r_cnt + 1'b1;
      r_num   <= w_num;
      r_found <= w_found;
      r_acc   <= w_acc;
      r_y     <= r_y >> STEP;
      r_sh    <= w_left ? (r_sh << STEP) : (r_sh >> STEP);
      if (r_cnt == CW'(NCYC - 1)) begin
        r_state <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
        result  <= w_res;
      end
    end else if (start) begin
      r_op    <= option;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_num   <= '0;
      r_found <= 1'b0;
      r_sh    <= {{XLEN{1'b0}}, in_x};
      r_y     <= in_y;
      r_state <= w_ok ? RUN : DONE;
      busy    <= w_ok;
      done    <= !w_ok;
      if (!w_ok) result <= in_x;
    end else begin
      r_state <= IDLE;
      done    <= 1'b0;
    end
  end
endmodule
